// File: rtl/music_player.sv
// Sample-rate sequencer for the music ROM: paces ROM reads, absorbs the
// one-cycle read latency and hands samples downstream over valid/ready.
module music_player #(
  parameter int CLK_DIV     = 1134,
  parameter int NUM_SAMPLES = 54832,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 17
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] Add,
  input  logic [DATA_W-1:0] music_content,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              playing,
  output logic              done,
  output logic [7:0]        overrun_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int                DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_SAMPLES - 1);

  logic [2:0]        state_r, state_s;
  logic [DIV_W-1:0]  div_cnt_r, div_cnt_s;
  logic              fetch_cnt_r, fetch_cnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s, next_addr_s;
  logic [DATA_W-1:0] sample_r, sample_s;
  logic              valid_r, valid_s;
  logic [7:0]        ovr_r, ovr_s;
  logic              playing_r, playing_s;
  logic              done_r, done_s;
  logic              tick_s, last_s;

  // Next-state logic; stop overrides start, which overrides normal sequencing.
  always_comb begin
    state_s     = state_r;
    div_cnt_s   = div_cnt_r;
    fetch_cnt_s = fetch_cnt_r;
    addr_s      = addr_r;
    sample_s    = sample_r;
    ovr_s       = ovr_r;
    tick_s      = (div_cnt_r == DIV_LAST);
    last_s      = (addr_r == ADDR_LAST);

    if (last_s) begin
      next_addr_s = {ADDR_W{1'b0}};
    end else begin
      next_addr_s = addr_r + ADDR_W'(1);
    end

    // The divider free-runs while active so the sample rate never drifts.
    if (state_r == S_WAIT || state_r == S_FETCH || state_r == S_DRAIN) begin
      if (tick_s) begin
        div_cnt_s = {DIV_W{1'b0}};
      end else begin
        div_cnt_s = div_cnt_r + DIV_W'(1);
      end
    end else begin
      div_cnt_s = {DIV_W{1'b0}};
    end

    if (valid_r && sample_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end

    case (state_r)
      S_IDLE: begin
        addr_s      = {ADDR_W{1'b0}};
        fetch_cnt_s = 1'b0;
      end
      S_WAIT: begin
        if (tick_s) begin
          if (valid_r) begin
            // Previous sample still pending: drop this period.
            if (ovr_r != 8'hFF) begin
              ovr_s = ovr_r + 8'd1;
            end else begin
              ovr_s = ovr_r;
            end
            addr_s = next_addr_s;
            if (last_s && !loop_en) begin
              state_s = S_DRAIN;
            end else begin
              state_s = S_WAIT;
            end
          end else begin
            state_s     = S_FETCH;
            fetch_cnt_s = 1'b0;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      S_FETCH: begin
        if (!fetch_cnt_r) begin
          fetch_cnt_s = 1'b1;
        end else begin
          sample_s = music_content;
          valid_s  = 1'b1;
          addr_s   = next_addr_s;
          if (last_s && !loop_en) begin
            state_s = S_DRAIN;
          end else begin
            state_s = S_WAIT;
          end
        end
      end
      S_DRAIN: begin
        if (!valid_r || sample_ready) begin
          state_s = S_DONE;
          valid_s = 1'b0;
          addr_s  = {ADDR_W{1'b0}};
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE: begin
        addr_s = {ADDR_W{1'b0}};
      end
      default: begin
        state_s = S_IDLE;
        valid_s = 1'b0;
        addr_s  = {ADDR_W{1'b0}};
      end
    endcase

    if (stop) begin
      state_s     = S_IDLE;
      valid_s     = 1'b0;
      addr_s      = {ADDR_W{1'b0}};
      div_cnt_s   = {DIV_W{1'b0}};
      fetch_cnt_s = 1'b0;
    end else if (start) begin
      state_s     = S_WAIT;
      valid_s     = 1'b0;
      addr_s      = {ADDR_W{1'b0}};
      div_cnt_s   = {DIV_W{1'b0}};
      fetch_cnt_s = 1'b0;
      ovr_s       = 8'd0;
    end else begin
      state_s = state_s;
    end

    playing_s = (state_s == S_WAIT) || (state_s == S_FETCH) || (state_s == S_DRAIN);
    done_s    = (state_s == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= S_IDLE;
      div_cnt_r   <= {DIV_W{1'b0}};
      fetch_cnt_r <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      sample_r    <= {DATA_W{1'b0}};
      valid_r     <= 1'b0;
      ovr_r       <= 8'd0;
      playing_r   <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_cnt_r   <= div_cnt_s;
      fetch_cnt_r <= fetch_cnt_s;
      addr_r      <= addr_s;
      sample_r    <= sample_s;
      valid_r     <= valid_s;
      ovr_r       <= ovr_s;
      playing_r   <= playing_s;
      done_r      <= done_s;
    end
  end

  assign Add          = addr_r;
  assign sample_out   = sample_r;
  assign sample_valid = valid_r;
  assign playing      = playing_r;
  assign done         = done_r;
  assign overrun_cnt  = ovr_r;

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with a registered ROM model returning 0x100+addr.
module tb_music_player;

  localparam int CLK_DIV     = 8;
  localparam int NUM_SAMPLES = 4;
  localparam int ADDR_W      = 17;
  localparam int DATA_W      = 17;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic              sample_ready = 1'b0;
  logic [ADDR_W-1:0] Add;
  logic [DATA_W-1:0] music_content = 17'h0;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              playing;
  logic              done;
  logic [7:0]        overrun_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  music_player #(
    .CLK_DIV(CLK_DIV), .NUM_SAMPLES(NUM_SAMPLES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .stop(stop), .loop_en(loop_en),
    .Add(Add), .music_content(music_content), .sample_out(sample_out),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .playing(playing), .done(done), .overrun_cnt(overrun_cnt)
  );

  always #5 Clk = ~Clk;

  // ROM model with one-cycle registered read latency.
  always @(posedge Clk) music_content <= 17'h100 + Add;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Start is raised at negedge N0 and dropped at N1; the task returns at N1.
  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset values
    cyc(2);
    chk("rst_add", 32'(Add), 32'h0);
    chk("rst_sample", 32'(sample_out), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_playing", 32'(playing), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ovr", 32'(overrun_cnt), 32'h0);
    Reset = 1'b0;
    cyc(1);

    // Asynchronous reset during the second FETCH
    sample_ready = 1'b1;
    pulse_start();
    cyc(16);
    chk("a_playing_pre", 32'(playing), 32'h1);
    chk("a_add_pre", 32'(Add), 32'h1);
    chk("a_sample_pre", 32'(sample_out), 32'h100);
    Reset = 1'b1;
    #1;
    chk("a_add", 32'(Add), 32'h0);
    chk("a_sample", 32'(sample_out), 32'h0);
    chk("a_playing", 32'(playing), 32'h0);
    chk("a_valid", 32'(sample_valid), 32'h0);
    chk("a_done", 32'(done), 32'h0);
    chk("a_ovr", 32'(overrun_cnt), 32'h0);
    cyc(1);
    Reset = 1'b0;
    cyc(1);

    // Full track, ready held high
    pulse_start();
    cyc(9);
    chk("b_valid_early", 32'(sample_valid), 32'h0);
    cyc(1);
    chk("b_valid0", 32'(sample_valid), 32'h1);
    chk("b_sample0", 32'(sample_out), 32'h100);
    cyc(1);
    chk("b_valid0_fall", 32'(sample_valid), 32'h0);
    for (int k = 1; k < 4; k++) begin
      cyc(7);
      chk("b_valid", 32'(sample_valid), 32'h1);
      chk("b_sample", 32'(sample_out), 32'h100 + 32'(k));
      cyc(1);
    end
    chk("b_done", 32'(done), 32'h1);
    chk("b_playing", 32'(playing), 32'h0);
    chk("b_add", 32'(Add), 32'h0);

    // Looping playback wraps from 0x103 to 0x100
    loop_en = 1'b1;
    pulse_start();
    cyc(10);
    chk("c_sample0", 32'(sample_out), 32'h100);
    cyc(1);
    for (int k = 1; k < 6; k++) begin
      cyc(7);
      chk("c_valid", 32'(sample_valid), 32'h1);
      chk("c_sample", 32'(sample_out), 32'h100 + 32'(k % 4));
      cyc(1);
    end
    chk("c_done", 32'(done), 32'h0);
    chk("c_playing", 32'(playing), 32'h1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("c_stop_playing", 32'(playing), 32'h0);
    chk("c_stop_add", 32'(Add), 32'h0);

    // Downstream stall drops two periods
    loop_en = 1'b0;
    sample_ready = 1'b0;
    pulse_start();
    cyc(10);
    chk("d_valid0", 32'(sample_valid), 32'h1);
    chk("d_sample0", 32'(sample_out), 32'h100);
    cyc(20);
    chk("d_ovr", 32'(overrun_cnt), 32'h2);
    chk("d_add", 32'(Add), 32'h3);
    chk("d_hold", 32'(sample_out), 32'h100);
    sample_ready = 1'b1;
    cyc(4);
    chk("d_valid3", 32'(sample_valid), 32'h1);
    chk("d_sample3", 32'(sample_out), 32'h103);
    cyc(1);
    chk("d_done", 32'(done), 32'h1);

    // stop and start together: stop wins
    sample_ready = 1'b0;
    pulse_start();
    cyc(10);
    chk("e_valid_pre", 32'(sample_valid), 32'h1);
    cyc(2);
    stop = 1'b1;
    start = 1'b1;
    cyc(1);
    stop = 1'b0;
    start = 1'b0;
    chk("e_valid", 32'(sample_valid), 32'h0);
    chk("e_playing", 32'(playing), 32'h0);
    chk("e_done", 32'(done), 32'h0);
    chk("e_add", 32'(Add), 32'h0);
    sample_ready = 1'b1;
    pulse_start();
    cyc(10);
    chk("e_replay_valid", 32'(sample_valid), 32'h1);
    chk("e_replay_sample", 32'(sample_out), 32'h100);
    chk("e_replay_add", 32'(Add), 32'h1);

    // Continuous stall with looping: overrun counter saturates
    loop_en = 1'b1;
    sample_ready = 1'b0;
    pulse_start();
    cyc(808);
    chk("f_ovr_100", 32'(overrun_cnt), 32'd100);
    cyc(1808);
    chk("f_ovr_sat", 32'(overrun_cnt), 32'd255);
    chk("f_playing", 32'(playing), 32'h1);
    pulse_start();
    chk("f_ovr_clear", 32'(overrun_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
